// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage_if
// Brief    : Fetch-stage bundle: hazard/redirect controls, imem port, IF/ID outputs.
// Revision : 1.0
// ============================================================================
interface fetch_stage_if;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic [15:0] pc_out;
    logic [15:0] if_instruction;
    logic [15:0] id_instr;
    logic [15:0] id_pc_plus2;
    logic        id_valid;
    logic        fetch_halted;
    logic [15:0] fetch_count;

    // The fetch stage drives the memory address and the IF/ID contents.
    modport master (
        input  stall, redirect, redirect_pc, imem_rdata,
        output imem_addr, pc_out, if_instruction,
        output id_instr, id_pc_plus2, id_valid, fetch_halted, fetch_count
    );

    modport slave (
        output stall, redirect, redirect_pc, imem_rdata,
        input  imem_addr, pc_out, if_instruction,
        input  id_instr, id_pc_plus2, id_valid, fetch_halted, fetch_count
    );
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Brief    : WISC instruction fetch with IF/ID register, stall, redirect, HLT freeze.
// Revision : 1.0
// ============================================================================
module fetch_stage #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [15:0] NOP_INSTR  = 16'h0000,
    parameter logic [3:0]  HLT_OPCODE = 4'hF
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_stage_if.master fif
);
    localparam logic [15:0] c_PC_STEP   = 16'd2;
    localparam logic [15:0] c_COUNT_MAX = 16'hFFFF;

    logic [15:0] r_pc;
    logic [15:0] r_idInstr;
    logic [15:0] r_idPcPlus2;
    logic        r_idValid;
    logic        r_halted;
    logic [15:0] r_count;

    logic        w_isHlt;
    logic [15:0] w_pcPlus2;

    assign w_isHlt   = (fif.imem_rdata[15:12] == HLT_OPCODE);
    assign w_pcPlus2 = r_pc + c_PC_STEP;

    // Priority: reset > redirect > stall > halted > normal fetch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc        <= RESET_PC;
            r_idInstr   <= NOP_INSTR;
            r_idPcPlus2 <= 16'h0000;
            r_idValid   <= 1'b0;
            r_halted    <= 1'b0;
            r_count     <= 16'h0000;
        end else if (fif.redirect) begin
            // A HLT sitting in the branch shadow is squashed along with IF.
            r_pc      <= fif.redirect_pc;
            r_idInstr <= NOP_INSTR;
            r_idValid <= 1'b0;
            r_halted  <= 1'b0;
        end else if (fif.stall) begin
            r_pc <= r_pc;
        end else if (r_halted) begin
            r_idInstr <= NOP_INSTR;
            r_idValid <= 1'b0;
        end else begin
            r_idInstr   <= fif.imem_rdata;
            r_idPcPlus2 <= w_pcPlus2;
            r_idValid   <= 1'b1;
            if (r_count != c_COUNT_MAX) begin
                r_count <= r_count + 16'd1;
            end
            // The HLT itself is passed to ID once; fetch then freezes on it.
            if (w_isHlt) begin
                r_halted <= 1'b1;
            end else begin
                r_pc <= w_pcPlus2;
            end
        end
    end

    assign fif.imem_addr      = r_pc;
    assign fif.pc_out         = r_pc;
    assign fif.if_instruction = fif.imem_rdata;
    assign fif.id_instr       = r_idInstr;
    assign fif.id_pc_plus2    = r_idPcPlus2;
    assign fif.id_valid       = r_idValid;
    assign fif.fetch_halted   = r_halted;
    assign fif.fetch_count    = r_count;
endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Brief    : Scoreboard bench for fetch_stage: directed plan then random traffic.
// Revision : 1.0
// ============================================================================
module tb_fetch_stage;
    typedef struct {
        logic [15:0] pc;
        logic [15:0] ifInstr;
        logic [15:0] idInstr;
        logic [15:0] idPc2;
        logic        idValid;
        logic        halted;
        logic [15:0] count;
    } exp_t;

    logic clk;
    logic rst_n;
    fetch_stage_if fif ();

    fetch_stage #(
        .RESET_PC   (16'h0000),
        .NOP_INSTR  (16'h0000),
        .HLT_OPCODE (4'hF)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .fif   (fif)
    );

    logic [15:0] mem [0:65535];
    always_comb fif.imem_rdata = mem[fif.imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   nCmp  = 0;
    int   nFail = 0;
    exp_t expQ[$];
    exp_t e;

    // Reference state: the architectural view of the stage.
    logic [15:0] m_pc, m_idInstr, m_idPc2, m_count;
    logic        m_idValid, m_halted;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        nCmp++;
        if (act !== req) begin
            nFail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // One clock of stimulus: apply inputs, advance the model, queue expectation.
    task automatic drive(input logic rn, input logic st, input logic rd, input logic [15:0] rpc);
        logic [15:0] word;
        rst_n           = rn;
        fif.stall       = st;
        fif.redirect    = rd;
        fif.redirect_pc = rpc;
        word = mem[m_pc];
        if (!rn) begin
            m_pc = 16'h0000; m_idInstr = 16'h0000; m_idPc2 = 16'h0000;
            m_idValid = 1'b0; m_halted = 1'b0; m_count = 16'h0000;
        end else if (rd) begin
            m_pc = rpc; m_idInstr = 16'h0000; m_idValid = 1'b0; m_halted = 1'b0;
        end else if (st) begin
            // everything holds
        end else if (m_halted) begin
            m_idInstr = 16'h0000; m_idValid = 1'b0;
        end else begin
            m_idInstr = word;
            m_idPc2   = 16'(m_pc + 16'd2);
            m_idValid = 1'b1;
            m_count   = (m_count == 16'hFFFF) ? m_count : 16'(m_count + 16'd1);
            if (word[15:12] == 4'hF) m_halted = 1'b1;
            else                     m_pc = 16'(m_pc + 16'd2);
        end
        expQ.push_back('{pc: m_pc, ifInstr: mem[m_pc], idInstr: m_idInstr, idPc2: m_idPc2,
                         idValid: m_idValid, halted: m_halted, count: m_count});
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        #1;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            check("pc_out",         fif.pc_out,                 e.pc);
            check("imem_addr",      fif.imem_addr,              e.pc);
            check("if_instruction", fif.if_instruction,         e.ifInstr);
            check("id_instr",       fif.id_instr,               e.idInstr);
            check("id_pc_plus2",    fif.id_pc_plus2,            e.idPc2);
            check("id_valid",       {15'd0, fif.id_valid},      {15'd0, e.idValid});
            check("fetch_halted",   {15'd0, fif.fetch_halted},  {15'd0, e.halted});
            check("fetch_count",    fif.fetch_count,            e.count);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] w;
        rst_n = 1'b0; fif.stall = 1'b0; fif.redirect = 1'b0; fif.redirect_pc = 16'h0000;
        m_pc = 16'h0000; m_idInstr = 16'h0000; m_idPc2 = 16'h0000;
        m_idValid = 1'b0; m_halted = 1'b0; m_count = 16'h0000;
        // Random program image, roughly one word in eight is a HLT.
        for (int i = 0; i < 65536; i++) begin
            w = 16'($urandom);
            if ($urandom_range(0, 7) == 0) w[15:12] = 4'hF;
            else if (w[15:12] == 4'hF)     w[15:12] = 4'h0;
            mem[i] = w;
        end
        mem[16'h0000] = 16'h1123; mem[16'h0002] = 16'h2456;
        mem[16'h0004] = 16'h3789; mem[16'h0006] = 16'h4ABC;
        mem[16'h0008] = 16'hF000; mem[16'h000A] = 16'hF000;
        mem[16'h0020] = 16'h5111; mem[16'hFFFE] = 16'h6222;
        @(negedge clk);

        // Reset, straight-line code, stall at 0004, resume.
        drive(1'b0, 1'b0, 1'b0, 16'h0000);
        drive(1'b0, 1'b0, 1'b0, 16'h0000);
        drive(1'b1, 1'b0, 1'b0, 16'h0000);
        drive(1'b1, 1'b0, 1'b0, 16'h0000);
        drive(1'b1, 1'b1, 1'b0, 16'h0000);
        drive(1'b1, 1'b1, 1'b0, 16'h0000);
        drive(1'b1, 1'b0, 1'b0, 16'h0000);
        drive(1'b1, 1'b0, 1'b0, 16'h0000);
        // HLT at 0008, then frozen for several cycles (one stalled).
        for (int i = 0; i < 7; i++) drive(1'b1, (i == 3), 1'b0, 16'h0000);
        // Redirect beats stall and releases the halt.
        drive(1'b1, 1'b1, 1'b1, 16'h0040);
        drive(1'b1, 1'b0, 1'b0, 16'h0000);
        // HLT at 000A squashed by a redirect in the same cycle.
        drive(1'b1, 1'b0, 1'b1, 16'h000A);
        drive(1'b1, 1'b0, 1'b1, 16'h0020);
        drive(1'b1, 1'b0, 1'b0, 16'h0000);
        drive(1'b1, 1'b0, 1'b0, 16'h0000);
        // PC wrap at FFFE, then reset while halted on a HLT at 0000.
        drive(1'b1, 1'b0, 1'b1, 16'hFFFE);
        mem[16'h0000] = 16'hF123;
        drive(1'b1, 1'b0, 1'b0, 16'h0000);
        drive(1'b1, 1'b0, 1'b0, 16'h0000);
        drive(1'b1, 1'b0, 1'b0, 16'h0000);
        drive(1'b1, 1'b0, 1'b0, 16'h0000);
        drive(1'b0, 1'b1, 1'b0, 16'h0000);
        drive(1'b1, 1'b0, 1'b1, 16'h0101);
        // Odd redirect target passes through unmodified.
        drive(1'b1, 1'b0, 1'b0, 16'h0000);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 63) != 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255)));
        end

        @(posedge clk);
        #2;
        check("scoreboard_drain", 16'(expQ.size()), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage plus IF/ID pipeline register for the 16-bit WISC pipelined cpu. It owns the PC, drives the instruction-memory address, and presents the fetched word as if_instruction. It registers the instruction and PC+2 into ID, and handles stall, branch-redirect flush and HLT freeze. It sits directly upstream of decode and feeds the cpu's pc_out and Inst trace signals.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset.
NOP_INSTR, 16'h0000, bubble word written to id_instr when no valid instruction is passed.
HLT_OPCODE, 4'hF, value of instr[15:12] that identifies HLT.

Ports:
clk  in  1  clock; all state updates on posedge.
rst_n  in  1  synchronous reset, active-low.
stall  in  1  hazard unit: hold PC and IF/ID.
redirect  in  1  branch/jump taken, resolved in ID; flushes IF.
redirect_pc  in  16  target PC when redirect=1.
imem_addr  out  16  instruction memory address (= pc).
imem_rdata  in  16  instruction word; combinational read, valid in the same cycle as imem_addr.
pc_out  out  16  current PC.
if_instruction  out  16  word fetched this cycle (= imem_rdata).
id_instr  out  16  IF/ID register: instruction.
id_pc_plus2  out  16  IF/ID register: fetch PC + 2.
id_valid  out  1  IF/ID holds a real instruction.
fetch_halted  out  1  HLT fetched; fetch frozen.
fetch_count  out  16  count of instructions accepted into ID, saturating.

Behaviour:
- Reset is synchronous: when rst_n=0 at posedge, pc<=RESET_PC, id_instr<=NOP_INSTR, id_pc_plus2<=0, id_valid<=0, fetch_halted<=0, fetch_count<=0.
- imem_addr=pc_out=pc. if_instruction=imem_rdata, combinational with zero latency.
- is_hlt = (imem_rdata[15:12]==HLT_OPCODE).
- Per-cycle priority (highest first): reset > redirect > stall > halted > normal.
- redirect=1:
  - pc<=redirect_pc.
  - id_instr<=NOP_INSTR, id_valid<=0.
  - fetch_halted<=0, because a HLT fetched in the branch shadow is squashed.
  - Redirect overrides a simultaneous stall.
- stall=1 (no redirect): pc, id_*, fetch_halted and fetch_count all hold.
- fetch_halted=1 (no redirect, no stall):
  - pc holds.
  - id_instr<=NOP_INSTR, id_valid<=0, count holds.
- Normal fetch:
  - id_instr<=imem_rdata, id_pc_plus2<=pc+2, id_valid<=1.
  - fetch_count<=fetch_count+1, saturating at 16'hFFFF.
  - If is_hlt: pc holds and fetch_halted<=1. The HLT itself enters ID as valid, exactly once.
  - Otherwise pc<=pc+2.
- PC arithmetic is 16-bit modulo: 16'hFFFE+2 -> 16'h0000. id_pc_plus2 wraps the same way. redirect_pc bit0 is passed through unmodified.
- Once halted, the stage stays frozen until reset or redirect; there is no other exit.
- Reset asserted mid-stall or mid-halt takes effect at that posedge and clears all state.
- No combinational path from stall/redirect to imem_addr; imem_addr changes only at clock edges.

Test Plan:
1. Reset then straight-line code: rst_n low for 2 edges, then imem returns 0x1123, 0x2456, 0x3789. Required: pc_out runs 0000,0002,0004,0006; id_instr follows one cycle late; id_pc_plus2=0002,0004,0006; fetch_count=3.
2. Stall: assert stall for 2 cycles at pc=0004. Required: pc_out stays 0004, id_* unchanged, fetch_count unchanged. Fetch resumes to 0006 on the first cycle after stall deasserts.
3. Redirect with simultaneous stall: redirect=1, redirect_pc=0x0040, stall=1. Required: next pc_out=0040, id_valid=0, id_instr=0000.
4. HLT: imem_rdata=0xF000 at pc=0008. Required: id_instr=F000, id_valid=1 once; pc_out frozen at 0008, fetch_halted=1; id_valid=0 thereafter for 5+ cycles.
5. HLT squashed: HLT fetched at pc=000A while redirect=1, redirect_pc=0x0020. Required: fetch_halted=0, pc_out=0020, F000 never valid in ID.
6. Wrap and reset: force pc=FFFE via redirect. Required: next pc_out=0000, id_pc_plus2=0000. Then drop rst_n during halt: next cycle pc_out=0000, fetch_halted=0, fetch_count=0.
